// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if
//   Instruction-memory request/acknowledge bundle for the fetch stage.
//
//   ImemReq   fetch -> memory  request valid; held with a stable ImemAddr
//                              until the memory acknowledges
//   ImemAddr  fetch -> memory  word address, bits [1:0] always zero
//   ImemAck   memory -> fetch  ImemData carries the requested word this cycle
//   ImemData  memory -> fetch  instruction word, meaningful only with ImemAck
//
//   master: the fetch stage side.  slave: the instruction-memory side.
// ---------------------------------------------------------------------------
interface if_fetch_stage_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemAck,
    input  ImemData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemAck,
    output ImemData
  );
endinterface

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   MIPS instruction-fetch stage with the IF/ID pipeline register.
//   Holds the PC, fetches one word per request over a req/ack handshake,
//   and loads {instruction, PC+4} into IF/ID. A one-entry skid buffer
//   absorbs a word that returns while decode is stalled; a branch/jump
//   redirect flushes IF/ID and, if a request is still in flight, waits for
//   it to complete and throws its data away.
//
//   Parameter RESET_PC : PC loaded on reset.
//
//   Ports
//     Clk           clock, all state updates on the rising edge
//     Rst           synchronous active-high reset
//     imem          instruction-memory bundle (master side)
//     Stall         decode stall, hold IF/ID
//     BranchTaken   redirect from decode (overrides Stall)
//     BranchTarget  redirect address, bits [1:0] forced to 00
//     PC            current fetch PC
//     IfIdInstr     IF/ID instruction
//     IfIdPCPlus4   IF/ID PC+4
//     IfIdValid     IF/ID holds a real instruction (0 = bubble)
//     Imm16         IfIdInstr[15:0] for the decode sign extender
//
//   Optional: define FETCH_PERF_EN to add PerfFetched / PerfBubbles
//   counters (IF/ID written valid / written as a bubble).
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                Clk,
  input  logic                Rst,
  if_fetch_stage_if.master    imem,
  input  logic                Stall,
  input  logic                BranchTaken,
  input  logic [31:0]         BranchTarget,
  output logic [31:0]         PC,
  output logic [31:0]         IfIdInstr,
  output logic [31:0]         IfIdPCPlus4,
  output logic                IfIdValid,
  output logic [15:0]         Imm16
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         PerfFetched,
  output logic [31:0]         PerfBubbles
`endif
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pc4_reg, pc4_next;
  logic        valid_reg, valid_next;
  logic [31:0] skid_instr_reg, skid_instr_next;
  logic [31:0] skid_pc4_reg, skid_pc4_next;

  logic        imem_req;
  logic        ack;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        wr_valid;
  logic        wr_bubble;

  // Redirect address low bits are always discarded.
  logic        unused_target_bits;
  assign unused_target_bits = ^BranchTarget[1:0];

  assign pc_plus4 = pc_reg + 32'd4;
  assign target   = {BranchTarget[31:2], 2'b00};

  // Request is gated by Rst so it stays low while reset is held and first
  // rises in the cycle after reset is released.
  assign imem_req = !Rst && (state_reg != HOLD);
  // An acknowledge with no request outstanding is meaningless.
  assign ack      = imem.ImemAck && imem_req;

  // ---------------- state register ----------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      req_addr_reg   <= RESET_PC;
      instr_reg      <= 32'h0;
      pc4_reg        <= 32'h0;
      valid_reg      <= 1'b0;
      skid_instr_reg <= 32'h0;
      skid_pc4_reg   <= 32'h0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      req_addr_reg   <= req_addr_next;
      instr_reg      <= instr_next;
      pc4_reg        <= pc4_next;
      valid_reg      <= valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc4_reg   <= skid_pc4_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH: begin
        if (BranchTaken)
          // The in-flight request must still complete before refetching.
          state_next = ack ? FETCH : DISCARD;
        else if (ack && Stall)
          state_next = HOLD;
        else
          state_next = FETCH;
      end
      HOLD: begin
        if (BranchTaken || !Stall)
          state_next = FETCH;
      end
      DISCARD: begin
        if (ack)
          state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // ---------------- datapath / output logic ----------------
  always_comb begin
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    pc4_next        = pc4_reg;
    valid_next      = valid_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc4_next   = skid_pc4_reg;
    wr_valid        = 1'b0;
    wr_bubble       = 1'b0;

    if (BranchTaken) begin
      pc_next         = target;
      instr_next      = 32'h0;
      valid_next      = 1'b0;
      skid_instr_next = 32'h0;
      skid_pc4_next   = 32'h0;
      wr_bubble       = 1'b1;
    end else begin
      case (state_reg)
        FETCH: begin
          if (ack) begin
            pc_next = pc_plus4;
            if (!Stall) begin
              instr_next = imem.ImemData;
              pc4_next   = pc_plus4;
              valid_next = 1'b1;
              wr_valid   = 1'b1;
            end else begin
              skid_instr_next = imem.ImemData;
              skid_pc4_next   = pc_plus4;
            end
          end else if (!Stall) begin
            valid_next = 1'b0;
            wr_bubble  = 1'b1;
          end
        end
        HOLD: begin
          if (!Stall) begin
            instr_next = skid_instr_reg;
            pc4_next   = skid_pc4_reg;
            valid_next = 1'b1;
            wr_valid   = 1'b1;
          end
        end
        default: ;  // DISCARD: returning data is dropped, IF/ID untouched
      endcase
    end

    // While discarding, the address of the old request must stay on the bus;
    // everywhere else the request address follows the PC.
    req_addr_next = (state_next == DISCARD) ? req_addr_reg : pc_next;
  end

  assign imem.ImemReq  = imem_req;
  assign imem.ImemAddr = req_addr_reg;
  assign PC            = pc_reg;
  assign IfIdInstr     = instr_reg;
  assign IfIdPCPlus4   = pc4_reg;
  assign IfIdValid     = valid_reg;
  assign Imm16         = instr_reg[15:0];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_bubbles_reg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      perf_fetched_reg <= 32'h0;
      perf_bubbles_reg <= 32'h0;
    end else begin
      if (wr_valid)
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      if (wr_bubble)
        perf_bubbles_reg <= perf_bubbles_reg + 32'd1;
    end
  end

  assign PerfFetched = perf_fetched_reg;
  assign PerfBubbles = perf_bubbles_reg;
`else
  logic unused_perf;
  assign unused_perf = wr_valid ^ wr_bubble;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//   Instruction memory model with per-request latency, a decode-side driver
//   that issues stalls and redirects, and a scoreboard holding the program
//   order the decode stage must see. A second instance (RESET_PC at the top
//   of the address space, zero-wait memory) exercises PC+4 wrap-around.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_if_fetch_stage;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] PC, IfIdInstr, IfIdPCPlus4;
  logic        IfIdValid;
  logic [15:0] Imm16;

  logic [31:0] u2_pc, u2_instr, u2_pc4;
  logic        u2_valid;
  logic [15:0] u2_imm16;

  if_fetch_stage_if imem();
  if_fetch_stage_if imem2();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
  logic [31:0] u2_perf_fetched, u2_perf_bubbles;
`endif

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Rst(Rst), .imem(imem),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .PC(PC), .IfIdInstr(IfIdInstr), .IfIdPCPlus4(IfIdPCPlus4),
    .IfIdValid(IfIdValid), .Imm16(Imm16)
`ifdef FETCH_PERF_EN
    , .PerfFetched(perf_fetched), .PerfBubbles(perf_bubbles)
`endif
  );

  // Zero-wait memory returning address | A0000000.
  assign imem2.ImemAck  = imem2.ImemReq;
  assign imem2.ImemData = imem2.ImemAddr | 32'hA000_0000;

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u2 (
    .Clk(Clk), .Rst(Rst), .imem(imem2),
    .Stall(1'b0), .BranchTaken(1'b0), .BranchTarget(32'h0),
    .PC(u2_pc), .IfIdInstr(u2_instr), .IfIdPCPlus4(u2_pc4),
    .IfIdValid(u2_valid), .Imm16(u2_imm16)
`ifdef FETCH_PERF_EN
    , .PerfFetched(u2_perf_fetched), .PerfBubbles(u2_perf_bubbles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Program contents: any address maps to a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA000_0000;
  endfunction

  // ---------------- instruction memory model ----------------
  int          lat_mode    = 0;   // <0: random 0..3 wait cycles, else fixed
  bit          spurious_en = 1'b0;
  bit          pending;
  int          lat_left;
  logic [31:0] pend_addr;

  initial begin
    imem.ImemAck  = 1'b0;
    imem.ImemData = 32'h0;
    pending       = 1'b0;
    lat_left      = 0;
    pend_addr     = 32'h0;
    forever begin
      @(posedge Clk);
      #2;
      if (Rst) begin
        pending       = 1'b0;
        imem.ImemAck  = 1'b0;
        imem.ImemData = 32'h0;
      end else if (imem.ImemReq) begin
        if (!pending) begin
          pending   = 1'b1;
          pend_addr = imem.ImemAddr;
          lat_left  = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
          check("addr_align", {30'h0, imem.ImemAddr[1:0]}, 32'h0);
        end else begin
          check("addr_stable", imem.ImemAddr, pend_addr);
        end
        if (lat_left == 0) begin
          imem.ImemAck  = 1'b1;
          imem.ImemData = mem_word(pend_addr);
          pending       = 1'b0;
        end else begin
          lat_left--;
          imem.ImemAck  = 1'b0;
          imem.ImemData = $urandom;
        end
      end else begin
        // Acks without a request must be ignored by the fetch stage.
        imem.ImemAck  = spurious_en && ($urandom_range(4, 0) == 0);
        imem.ImemData = $urandom;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_addr = 32'h0;  // next address decode should receive
  int          consumed = 0;
  int          stall_pct = 0;
  int          br_pct    = 0;

  // Decode accepts the IF/ID contents on every valid, unstalled cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (!Rst && IfIdValid && !Stall) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: actual=%h required=none", IfIdInstr);
        end else begin
          e = exp_q.pop_front();
          check("ifid_instr", IfIdInstr, e.instr);
          check("ifid_pc4", IfIdPCPlus4, e.pc4);
          check("imm16", {16'h0, Imm16}, {16'h0, e.instr[15:0]});
          consumed++;
        end
      end
    end
  end

  // ---------------- decode-side driver ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply(input bit rst_v, input bit fb, input logic [31:0] tgt, input bit fs);
    bit br, st;
    Rst = rst_v;
    if (rst_v) begin
      Stall       = 1'b0;
      BranchTaken = 1'b0;
      exp_q.delete();
      exp_addr    = 32'h0;
    end else begin
      br = fb || (int'($urandom_range(99, 0)) < br_pct);
      st = !br && (fs || (int'($urandom_range(99, 0)) < stall_pct));
      Stall        = st;
      BranchTaken  = br;
      BranchTarget = fb ? tgt : ($urandom & 32'h0003_FFFF);
      if (IfIdValid && !st) begin
        exp_q.push_back('{instr: mem_word(exp_addr), pc4: exp_addr + 32'd4});
        exp_addr = exp_addr + 32'd4;
      end
      if (br)
        exp_addr = {BranchTarget[31:2], 2'b00};
    end
  endtask

  task automatic drive(input bit rst_v);
    tick();
    apply(rst_v, 1'b0, 32'h0, 1'b0);
  endtask

  // Waits for a valid IF/ID cycle and redirects on it; the next request has
  // just been issued so it is still outstanding.
  task automatic branch_on_valid(input logic [31:0] tgt, output bit found);
    found = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (IfIdValid) begin
        apply(1'b0, 1'b1, tgt, 1'b0);
        found = 1'b1;
        break;
      end
      apply(1'b0, 1'b0, 32'h0, 1'b0);
    end
  endtask

  initial begin
    bit found;
    int seen;
    int c0;

    Rst          = 1'b1;
    Stall        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = 32'h0;

    // ---- reset state ----
    repeat (3) drive(1'b1);
    @(negedge Clk);
    check("rst_req", {31'h0, imem.ImemReq}, 32'h0);
    check("rst_valid", {31'h0, IfIdValid}, 32'h0);
    check("rst_instr", IfIdInstr, 32'h0);
    check("rst_pc4", IfIdPCPlus4, 32'h0);
    check("rst_pc", PC, 32'h0);
    check("rst_addr", imem.ImemAddr, 32'h0);
    check("rst_imm16", {16'h0, Imm16}, 32'h0);
    check("u2_rst_pc", u2_pc, 32'hFFFF_FFFC);
    check("u2_rst_req", {31'h0, imem2.ImemReq}, 32'h0);

    // ---- zero-wait memory: one instruction per cycle, PC+4 wrap ----
    lat_mode = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b0);
      @(negedge Clk);
      if (i == 0) begin
        check("zw_req", {31'h0, imem.ImemReq}, 32'h1);
        check("zw_addr0", imem.ImemAddr, 32'h0);
        check("u2_addr0", imem2.ImemAddr, 32'hFFFF_FFFC);
      end
      if (i == 1) begin
        check("u2_wrap_pc4", u2_pc4, 32'h0);
        check("u2_wrap_instr", u2_instr, 32'hFFFF_FFFC);
        check("u2_wrap_addr", imem2.ImemAddr, 32'h0);
      end
      if (i == 2) begin
        check("u2_instr1", u2_instr, 32'hA000_0000);
        check("u2_pc4_1", u2_pc4, 32'h4);
        check("u2_imm16_1", {16'h0, u2_imm16}, 32'h0);
      end
      if (i >= 1) begin
        check("zw_valid", {31'h0, IfIdValid}, 32'h1);
        check("u2_valid", {31'h0, u2_valid}, 32'h1);
      end
    end

    // ---- stall 3 cycles while an ack arrives: HOLD drops the request ----
    tick(); apply(1'b0, 1'b0, 32'h0, 1'b1);  // ack captured into skid
    for (int i = 0; i < 3; i++) begin
      tick();
      apply(1'b0, 1'b0, 32'h0, (i < 2));
      @(negedge Clk);
      check("hold_req", {31'h0, imem.ImemReq}, 32'h0);
    end
    repeat (6) drive(1'b0);

    // ---- two-cycle ack latency: two bubbles per instruction ----
    repeat (2) drive(1'b1);
    lat_mode = 2;
    seen = 0;
    for (int i = 0; i < 40 && seen < 4; i++) begin
      drive(1'b0);
      @(negedge Clk);
      if (IfIdValid) begin
        seen++;
        if (seen == 4) begin
          check("lat2_4th_cycle", i, 12);
`ifdef FETCH_PERF_EN
          check("perf_fetched", perf_fetched, 32'd4);
          check("perf_bubbles", perf_bubbles, 32'd8);
`endif
        end
      end
    end
    check("lat2_seen", seen, 4);

    // ---- redirect while a request is outstanding ----
    branch_on_valid(32'h0000_1003, found);
    check("br_found", {31'h0, found}, 32'h1);
    drive(1'b0);
    @(negedge Clk);
    check("br_valid", {31'h0, IfIdValid}, 32'h0);
    check("br_instr", IfIdInstr, 32'h0);
    check("br_pc", PC, 32'h0000_1000);
    drive(1'b0);
    @(negedge Clk);
    check("disc_req", {31'h0, imem.ImemReq}, 32'h1);
    check("disc_valid", {31'h0, IfIdValid}, 32'h0);
    drive(1'b0);
    @(negedge Clk);
    check("br_new_addr", imem.ImemAddr, 32'h0000_1000);
    check("br_new_req", {31'h0, imem.ImemReq}, 32'h1);
    check("br_late_valid", {31'h0, IfIdValid}, 32'h0);
    repeat (10) drive(1'b0);

    // ---- reset in the middle of DISCARD ----
    branch_on_valid(32'h0000_2468, found);
    check("br2_found", {31'h0, found}, 32'h1);
    drive(1'b1);
    drive(1'b1);
    @(negedge Clk);
    check("mid_rst_req", {31'h0, imem.ImemReq}, 32'h0);
    check("mid_rst_valid", {31'h0, IfIdValid}, 32'h0);
    check("mid_rst_instr", IfIdInstr, 32'h0);
    check("mid_rst_pc4", IfIdPCPlus4, 32'h0);
    check("mid_rst_pc", PC, 32'h0);
    check("mid_rst_addr", imem.ImemAddr, 32'h0);

    // ---- randomized traffic ----
    lat_mode    = -1;
    spurious_en = 1'b1;
    stall_pct   = 30;
    br_pct      = 6;
    c0 = consumed;
    for (int i = 0; i < 3000; i++) begin
      drive((i % 500) >= 498);
    end
    @(negedge Clk);
    n_cmp++;
    if (consumed - c0 < 200) begin
      n_bad++;
      $display("FAIL rand_progress: actual=%0d required>=200", consumed - c0);
    end
    check("sb_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the MIPS pipeline.
- Holds the PC and issues word requests to instruction memory over a req/ack handshake.
- Latches the returned instruction and PC+4 into the IF/ID register.
- Imm16 (IF/ID instruction bits [15:0]) feeds the decode-stage sign extender directly.
- Handles decode stalls with a one-entry skid buffer, and branch/jump redirects with a flush.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- ImemReq  out  1  instruction-memory request.
- ImemAddr  out  32  word address of the request; bits [1:0] always 0.
- ImemAck  in  1  memory has returned ImemData for the current request.
- ImemData  in  32  instruction word, valid when ImemAck=1.
- Stall  in  1  decode stall: hold IF/ID.
- BranchTaken  in  1  redirect request from decode.
- BranchTarget  in  32  redirect address; bits [1:0] ignored, forced to 00.
- PC  out  32  current fetch PC.
- IfIdInstr  out  32  IF/ID instruction.
- IfIdPCPlus4  out  32  IF/ID PC+4.
- IfIdValid  out  1  IF/ID holds a real instruction; 0 means bubble.
- Imm16  out  16  IfIdInstr[15:0], routed to the sign extender.

Behaviour:
- Reset: takes effect on any edge with Rst=1, regardless of state or outstanding request. All state is overwritten: PC=RESET_PC, ReqAddr=RESET_PC, IfIdInstr=0 (NOP), IfIdPCPlus4=0, IfIdValid=0, skid empty, state=FETCH, ImemReq=0. ImemReq first asserts in the cycle after Rst deasserts.
- Handshake: ImemReq is held high with ImemAddr=ReqAddr stable until the cycle ImemAck=1. Zero-wait memory (ack in the same cycle as req) gives one instruction per cycle. Ack while ImemReq=0 is ignored.
- States: FETCH, HOLD, DISCARD.
- FETCH: ImemReq=1. ReqAddr tracks PC.
  - Ack, !Stall, !BranchTaken: IfIdInstr<=ImemData; IfIdPCPlus4<=PC+4; IfIdValid<=1; PC<=PC+4.
  - Ack, Stall, !BranchTaken: skid<={ImemData, PC+4}; PC<=PC+4; IF/ID held; go to HOLD.
  - No ack, !Stall: IfIdValid<=0 (bubble); IfIdInstr and IfIdPCPlus4 keep their values.
  - No ack, Stall: IF/ID held.
- HOLD: ImemReq=0.
  - While Stall=1: IF/ID held.
  - First cycle with Stall=0: IF/ID<=skid; IfIdValid<=1; go to FETCH.
- DISCARD: ImemReq=1 with the old ReqAddr.
  - On ack: data dropped; ReqAddr<=PC; go to FETCH.
- BranchTaken: highest priority after Rst; also overrides Stall.
  - PC<={BranchTarget[31:2],2'b00}; IfIdValid<=0; IfIdInstr<=0; skid cleared.
  - From FETCH with no ack that cycle: go to DISCARD, because the outstanding request must complete.
  - Otherwise (FETCH with ack, HOLD, or DISCARD): any same-cycle ImemData is dropped. From FETCH or HOLD go to FETCH at the new PC; from DISCARD stay in DISCARD until the ack.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Imm16: purely combinational from the IfIdInstr register; no added latency.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds outputs PerfFetched[31:0] and PerfBubbles[31:0]; both reset to 0.
  - PerfFetched increments on each cycle IfIdValid is written 1 from memory or skid.
  - PerfBubbles increments on each cycle IfIdValid is written 0 (including flushes).
  - Both wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Zero-wait memory (ImemAck tied to ImemReq, ImemData=ImemAddr|32'hA0000000), RESET_PC=0 -> IfIdInstr sequence 32'hA0000000, 32'hA0000004, … on consecutive cycles; IfIdPCPlus4 = 4, 8, …; Imm16 = 16'h0000, 16'h0004, ….
- Ack delayed 2 cycles per request -> 2 bubble cycles (IfIdValid=0) between valid instructions; ImemAddr stable while ImemReq=1.
- Stall=1 for 3 cycles while an ack arrives -> IF/ID unchanged for the 3 cycles; ImemReq=0 in HOLD; the skid instruction appears on the cycle after Stall drops; no instruction lost or duplicated.
- BranchTaken with BranchTarget=32'h0000_1003 while a request is outstanding (ack 2 cycles later) -> IfIdValid=0 and IfIdInstr=0 next cycle; late data discarded; next ImemAddr=32'h0000_1000.
- RESET_PC=32'hFFFF_FFFC, zero-wait -> first IfIdPCPlus4=0, next ImemAddr=0. Rst asserted mid-DISCARD -> all outputs at reset values next cycle; ImemReq=0.
- FETCH_PERF_EN defined, scenario 2 run for 4 instructions -> PerfFetched=4, PerfBubbles=8 (2 bubbles per delayed request × 4 requests, including the initial fill).
